// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and position helpers for the Enigma step controller.
// Pure declarations: no latency, no backpressure.
package enigma_pkg;

  typedef logic [4:0] char_t;

  localparam char_t ALPHA_MAX    = 5'd25;
  localparam char_t CHAR_INVALID = 5'd31;

  localparam int NOTCH0_DEF  = 21;
  localparam int NOTCH1_DEF  = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic char_t rot_inc(input char_t p);
    return (p >= ALPHA_MAX) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-alphabet configuration values fall back to position 0.
  function automatic char_t pos_clamp(input char_t p);
    return (p > ALPHA_MAX) ? 5'd0 : p;
  endfunction

endpackage

// File: rtl/enigma_step_ctrl_if.sv
// Front-end, result and datapath signals of the step controller.
// Bundle only: no latency, no backpressure of its own.
interface enigma_step_ctrl_if;
  import enigma_pkg::*;

  logic  cfg_load;
  char_t cfg_pos0, cfg_pos1, cfg_pos2;
  logic  in_valid;
  char_t in_char;
  logic  in_ready;
  logic  out_valid;
  char_t out_char;
  logic  out_err;
  logic  out_ready;
  logic  dp_start;
  char_t dp_char;
  char_t dp_pos0, dp_pos1, dp_pos2;
  char_t dp_result;
  logic  dp_done;
  logic  busy;

  modport slave (
    input  cfg_load, cfg_pos0, cfg_pos1, cfg_pos2,
    input  in_valid, in_char,
    output in_ready,
    output out_valid, out_char, out_err,
    input  out_ready,
    output dp_start, dp_char, dp_pos0, dp_pos1, dp_pos2,
    input  dp_result, dp_done,
    output busy
  );

  modport master (
    output cfg_load, cfg_pos0, cfg_pos1, cfg_pos2,
    output in_valid, in_char,
    input  in_ready,
    input  out_valid, out_char, out_err,
    output out_ready,
    input  dp_start, dp_char, dp_pos0, dp_pos1, dp_pos2,
    output dp_result, dp_done,
    input  busy
  );

endinterface

// File: rtl/enigma_rotor_stepper.sv
// Next rotor positions for one keypress, including the middle-rotor double step.
// Combinational, zero latency; no backpressure.
module enigma_rotor_stepper
  import enigma_pkg::*;
(
  input  char_t pos0,
  input  char_t pos1,
  input  char_t pos2,
  input  char_t notch0,
  input  char_t notch1,
  output char_t pos0_nxt,
  output char_t pos1_nxt,
  output char_t pos2_nxt
);

  logic step1, step2;

  // The middle rotor at its own notch moves itself and the slow rotor.
  assign step2 = (pos1 == notch1);
  assign step1 = (pos0 == notch0) || step2;

  assign pos0_nxt = rot_inc(pos0);
  assign pos1_nxt = step1 ? rot_inc(pos1) : pos1;
  assign pos2_nxt = step2 ? rot_inc(pos2) : pos2;

endmodule

// File: rtl/enigma_step_ctrl.sv
// Per-letter sequencer: steps rotors, drives the datapath, returns the ciphertext.
// Latency: 4 cycles from acceptance to out_valid when dp_done comes in the first WAIT cycle.
// Backpressure: one letter in flight; in_ready low outside IDLE, result held until out_ready.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int NOTCH0  = NOTCH0_DEF,
  parameter int NOTCH1  = NOTCH1_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  enigma_step_ctrl_if.slave ctl
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam char_t           NOTCH0_C = char_t'(NOTCH0);
  localparam char_t           NOTCH1_C = char_t'(NOTCH1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  char_t         pos0_q, pos1_q, pos2_q;
  char_t         pos0_nxt, pos1_nxt, pos2_nxt;
  char_t         char_q, res_q;
  logic          err_q;
  logic [CW-1:0] tmo_q;
  logic          tmo_expire;
  logic          char_bad;
  logic          in_ready_c, out_valid_c, dp_start_c, busy_c;

  assign tmo_expire = (tmo_q == TMO_LAST);
  assign char_bad   = (ctl.in_char > ALPHA_MAX);

  enigma_rotor_stepper u_stepper (
    .pos0     (pos0_q),
    .pos1     (pos1_q),
    .pos2     (pos2_q),
    .notch0   (NOTCH0_C),
    .notch1   (NOTCH1_C),
    .pos0_nxt (pos0_nxt),
    .pos1_nxt (pos1_nxt),
    .pos2_nxt (pos2_nxt)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    dp_start_c  = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      IDLE: begin
        busy_c     = 1'b0;
        in_ready_c = !ctl.cfg_load;
        if (!ctl.cfg_load && ctl.in_valid) begin
          state_d = char_bad ? OUT : STEP;
        end
      end
      STEP:  state_d = ISSUE;
      ISSUE: begin
        dp_start_c = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ctl.dp_done || tmo_expire) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (ctl.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos0_q  <= '0;
      pos1_q  <= '0;
      pos2_q  <= '0;
      char_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ctl.cfg_load) begin
            pos0_q <= pos_clamp(ctl.cfg_pos0);
            pos1_q <= pos_clamp(ctl.cfg_pos1);
            pos2_q <= pos_clamp(ctl.cfg_pos2);
          end else if (ctl.in_valid) begin
            // A bad letter is echoed back as the error result and never reaches the datapath.
            if (char_bad) begin
              res_q <= ctl.in_char;
              err_q <= 1'b1;
            end else begin
              char_q <= ctl.in_char;
            end
          end
        end
        STEP: begin
          pos0_q <= pos0_nxt;
          pos1_q <= pos1_nxt;
          pos2_q <= pos2_nxt;
        end
        ISSUE: tmo_q <= '0;
        WAIT: begin
          if (ctl.dp_done) begin
            res_q <= ctl.dp_result;
            err_q <= 1'b0;
          end else if (tmo_expire) begin
            res_q <= CHAR_INVALID;
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ctl.in_ready  = in_ready_c;
  assign ctl.out_valid = out_valid_c;
  assign ctl.out_char  = res_q;
  assign ctl.out_err   = err_q;
  assign ctl.dp_start  = dp_start_c;
  assign ctl.dp_char   = char_q;
  assign ctl.dp_pos0   = pos0_q;
  assign ctl.dp_pos1   = pos1_q;
  assign ctl.dp_pos2   = pos2_q;
  assign ctl.busy      = busy_c;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Bench for enigma_step_ctrl: stepper vector table plus scoreboarded letter sequences.
module tb_enigma_step_ctrl;
  import enigma_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enigma_step_ctrl_if ifc ();

  enigma_step_ctrl #(.NOTCH0(21), .NOTCH1(4), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ifc)
  );

  char_t st_p0, st_p1, st_p2, st_n0, st_n1, st_x0, st_x1, st_x2;

  enigma_rotor_stepper u_step (
    .pos0     (st_p0),
    .pos1     (st_p1),
    .pos2     (st_p2),
    .notch0   (st_n0),
    .notch1   (st_n1),
    .pos0_nxt (st_x0),
    .pos1_nxt (st_x1),
    .pos2_nxt (st_x2)
  );

  typedef struct {
    char_t p0, p1, p2, n0, n1, e0, e1, e2;
  } svec_t;

  typedef struct {
    char_t c;
    logic  e;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   dp_delay = 0;
  exp_t sbq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic svec_t mk(input int p0, p1, p2, n0, n1, e0, e1, e2);
    svec_t r;
    r.p0 = char_t'(p0); r.p1 = char_t'(p1); r.p2 = char_t'(p2);
    r.n0 = char_t'(n0); r.n1 = char_t'(n1);
    r.e0 = char_t'(e0); r.e1 = char_t'(e1); r.e2 = char_t'(e2);
    return r;
  endfunction

  task automatic chk_pos(input string nm, input int a0, input int a1, input int a2);
    chk({nm, "_pos0"}, int'(ifc.dp_pos0), a0);
    chk({nm, "_pos1"}, int'(ifc.dp_pos1), a1);
    chk({nm, "_pos2"}, int'(ifc.dp_pos2), a2);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, int'(ifc.in_ready), 1);
    chk({nm, "_out_valid"}, int'(ifc.out_valid), 0);
    chk({nm, "_out_char"}, int'(ifc.out_char), 0);
    chk({nm, "_out_err"}, int'(ifc.out_err), 0);
    chk({nm, "_dp_start"}, int'(ifc.dp_start), 0);
    chk({nm, "_dp_char"}, int'(ifc.dp_char), 0);
    chk({nm, "_busy"}, int'(ifc.busy), 0);
    chk_pos(nm, 0, 0, 0);
  endtask

  // Offers a letter at a falling edge; returns on the falling edge of the cycle after acceptance.
  task automatic accept(input int c, input bit push, input int ec, input int ee);
    exp_t x;
    int   k;
    @(negedge clk);
    k = 0;
    while (!ifc.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("accept_in_ready", int'(ifc.in_ready), 1);
    ifc.in_valid = 1'b1;
    ifc.in_char  = char_t'(c);
    if (push) begin
      x.c = char_t'(ec);
      x.e = (ee != 0);
      sbq.push_back(x);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  // Cycle index 1 is the first cycle after acceptance.
  task automatic track(output int t_issue, output int t_out, output int n_start,
                       output int p0, output int p1, output int p2, output int dc);
    t_issue = 0; t_out = 0; n_start = 0; p0 = -1; p1 = -1; p2 = -1; dc = -1;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) @(negedge clk);
      if (ifc.dp_start) begin
        n_start++;
        if (t_issue == 0) begin
          t_issue = k;
          p0 = int'(ifc.dp_pos0); p1 = int'(ifc.dp_pos1); p2 = int'(ifc.dp_pos2);
          dc = int'(ifc.dp_char);
        end
      end
      if (ifc.out_valid) begin
        t_out = k;
        break;
      end
    end
    if (t_out == 0) begin
      n_chk++;
      $display("FAIL track_out_valid: no out_valid within 64 cycles, expected one");
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ifc.busy && k < 64);
    chk({nm, "_idle"}, int'(ifc.busy), 0);
  endtask

  // Datapath model: result = (letter + 7) mod 26, dp_done in WAIT cycle dp_delay (0 = never).
  initial begin
    int    armed;
    char_t res;
    armed = 0;
    res = '0;
    ifc.dp_done = 1'b0;
    ifc.dp_result = '0;
    forever begin
      @(negedge clk);
      if (ifc.dp_start) begin
        armed = dp_delay;
        res = char_t'((int'(ifc.dp_char) + 7) % 26);
        ifc.dp_done = 1'b0;
      end else if (armed > 0) begin
        armed--;
        ifc.dp_done = (armed == 0);
        ifc.dp_result = res;
      end else begin
        ifc.dp_done = 1'b0;
      end
    end
  end

  // Scoreboard: every completed output handshake pops one expected result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && ifc.out_valid && ifc.out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got out_char %0d, expected no result", ifc.out_char);
        end else begin
          x = sbq.pop_front();
          chk("sb_out_char", int'(ifc.out_char), int'(x.c));
          chk("sb_out_err", int'(ifc.out_err), int'(x.e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    svec_t tv[8];
    int t_iss, t_out, n_st, p0, p1, p2, dc;
    int dchars[3];
    int exp_pos[3][3];

    ifc.cfg_load = 1'b0;
    ifc.cfg_pos0 = '0; ifc.cfg_pos1 = '0; ifc.cfg_pos2 = '0;
    ifc.in_valid = 1'b0;
    ifc.in_char = '0;
    ifc.out_ready = 1'b1;

    // Stepper in isolation: {pos0,pos1,pos2, notch0,notch1} -> next pos0..2.
    tv[0] = mk( 0,  0,  0, 21,  4,  1,  0,  0);
    tv[1] = mk(20,  3,  0, 21,  4, 21,  3,  0);
    tv[2] = mk(21,  3,  0, 21,  4, 22,  4,  0);
    tv[3] = mk(22,  4,  0, 21,  4, 23,  5,  1);
    tv[4] = mk(25, 25, 25, 25, 25,  0,  0,  0);
    tv[5] = mk(25,  4, 25, 21,  4,  0,  5,  0);
    tv[6] = mk(21,  4,  7, 21,  4, 22,  5,  8);
    tv[7] = mk(25, 25, 25, 21,  4,  0, 25, 25);
    for (int i = 0; i < 8; i++) begin
      st_p0 = tv[i].p0; st_p1 = tv[i].p1; st_p2 = tv[i].p2;
      st_n0 = tv[i].n0; st_n1 = tv[i].n1;
      #1;
      chk($sformatf("stepper_v%0d_pos0", i), int'(st_x0), int'(tv[i].e0));
      chk($sformatf("stepper_v%0d_pos1", i), int'(st_x1), int'(tv[i].e1));
      chk($sformatf("stepper_v%0d_pos2", i), int'(st_x2), int'(tv[i].e2));
    end

    @(negedge clk);
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic letter: 0/0/0, letter 0, datapath answers 7 in the first WAIT cycle.
    dp_delay = 1;
    accept(0, 1'b1, 7, 0);
    track(t_iss, t_out, n_st, p0, p1, p2, dc);
    chk("basic_dp_start_pulses", n_st, 1);
    chk("basic_issue_cycle", t_iss, 2);
    chk("basic_issue_pos0", p0, 1);
    chk("basic_issue_pos1", p1, 0);
    chk("basic_issue_pos2", p2, 0);
    chk("basic_issue_dp_char", dc, 0);
    chk("basic_latency", t_out, 4);
    wait_idle("basic");
    chk_pos("basic_after", 1, 0, 0);

    // cfg_load wins over a simultaneous letter.
    ifc.cfg_load = 1'b1;
    ifc.cfg_pos0 = 5'd20; ifc.cfg_pos1 = 5'd3; ifc.cfg_pos2 = 5'd0;
    ifc.in_valid = 1'b1;
    ifc.in_char = 5'd5;
    #1;
    chk("cfg_in_ready_low", int'(ifc.in_ready), 0);
    @(negedge clk);
    ifc.cfg_load = 1'b0;
    ifc.in_valid = 1'b0;
    chk("cfg_letter_not_taken", int'(ifc.busy), 0);
    chk_pos("cfg_load", 20, 3, 0);

    // Double step across three letters.
    dchars = '{1, 2, 3};
    exp_pos = '{'{21, 3, 0}, '{22, 4, 0}, '{23, 5, 1}};
    for (int i = 0; i < 3; i++) begin
      accept(dchars[i], 1'b1, dchars[i] + 7, 0);
      track(t_iss, t_out, n_st, p0, p1, p2, dc);
      chk($sformatf("dbl%0d_issue_pos0", i), p0, exp_pos[i][0]);
      chk($sformatf("dbl%0d_issue_pos1", i), p1, exp_pos[i][1]);
      chk($sformatf("dbl%0d_issue_pos2", i), p2, exp_pos[i][2]);
      chk($sformatf("dbl%0d_dp_char", i), dc, dchars[i]);
      wait_idle($sformatf("dbl%0d", i));
    end
    chk_pos("dbl_after", 23, 5, 1);

    // Invalid letter is echoed as an error without touching the datapath or rotors.
    accept(27, 1'b1, 27, 1);
    track(t_iss, t_out, n_st, p0, p1, p2, dc);
    chk("inv_dp_start_pulses", n_st, 0);
    chk("inv_latency", t_out, 1);
    wait_idle("inv");
    chk_pos("inv_after", 23, 5, 1);

    // Out-of-range configuration values load 0.
    @(negedge clk);
    ifc.cfg_load = 1'b1;
    ifc.cfg_pos0 = 5'd30; ifc.cfg_pos1 = 5'd7; ifc.cfg_pos2 = 5'd26;
    @(negedge clk);
    ifc.cfg_load = 1'b0;
    chk_pos("cfg_clamp", 0, 7, 0);

    // Timeout, then backpressure with an ignored cfg_load and letter during OUT.
    dp_delay = 0;
    ifc.out_ready = 1'b0;
    accept(4, 1'b1, 31, 1);
    track(t_iss, t_out, n_st, p0, p1, p2, dc);
    chk("tmo_issue_to_out", t_out - t_iss, TMO + 1);
    chk("tmo_issue_pos0", p0, 1);
    ifc.cfg_load = 1'b1;
    ifc.cfg_pos0 = 5'd9; ifc.cfg_pos1 = 5'd9; ifc.cfg_pos2 = 5'd9;
    ifc.in_valid = 1'b1;
    ifc.in_char = 5'd1;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk($sformatf("bp%0d_out_valid", h), int'(ifc.out_valid), 1);
      chk($sformatf("bp%0d_out_char", h), int'(ifc.out_char), 31);
      chk($sformatf("bp%0d_out_err", h), int'(ifc.out_err), 1);
      chk($sformatf("bp%0d_in_ready", h), int'(ifc.in_ready), 0);
      @(negedge clk);
    end
    ifc.cfg_load = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    wait_idle("bp");
    chk_pos("bp_after", 1, 7, 0);

    // dp_done in the very cycle the counter expires still counts as success.
    dp_delay = TMO;
    accept(10, 1'b1, 17, 0);
    track(t_iss, t_out, n_st, p0, p1, p2, dc);
    chk("late_done_issue_to_out", t_out - t_iss, TMO + 1);
    wait_idle("late_done");
    chk_pos("late_done_after", 2, 7, 0);

    // Reset while waiting on the datapath.
    dp_delay = 0;
    accept(2, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", int'(ifc.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst_mid_after");

    // Recovery after reset.
    dp_delay = 1;
    accept(5, 1'b1, 12, 0);
    track(t_iss, t_out, n_st, p0, p1, p2, dc);
    chk("recover_latency", t_out, 4);
    wait_idle("recover");
    chk_pos("recover_after", 1, 0, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
